// File: rtl/deadlock_watchdog_monitor_if.sv
// Signal bundle between a kernel under simulation and its deadlock watchdog.
// Stats ports exist only when DEADLOCK_MON_STATS_EN is defined.
interface deadlock_watchdog_monitor_if #(
   parameter int N_AXIS = 2,
   parameter int N_INST = 2,
   parameter int CNT_W  = 16
);
   logic [N_AXIS-1:0] axis_block_sigs;
   logic [N_INST-1:0] inst_idle_sigs;
   logic [N_INST-1:0] inst_block_sigs;
   logic              clear;
   logic              block;
   logic              block_pulse;
   logic [N_AXIS-1:0] axis_snapshot;
   logic [N_INST-1:0] inst_snapshot;
   logic [CNT_W-1:0]  stall_count;
   logic [1:0]        state;
`ifdef DEADLOCK_MON_STATS_EN
   logic [7:0]        event_count;
   logic [CNT_W-1:0]  max_stall;
`endif

   modport master (
      output axis_block_sigs,
      output inst_idle_sigs,
      output inst_block_sigs,
      output clear,
      input  block,
      input  block_pulse,
      input  axis_snapshot,
      input  inst_snapshot,
      input  stall_count,
      input  state
`ifdef DEADLOCK_MON_STATS_EN
      ,
      input  event_count,
      input  max_stall
`endif
   );

   modport slave (
      input  axis_block_sigs,
      input  inst_idle_sigs,
      input  inst_block_sigs,
      input  clear,
      output block,
      output block_pulse,
      output axis_snapshot,
      output inst_snapshot,
      output stall_count,
      output state
`ifdef DEADLOCK_MON_STATS_EN
      ,
      output event_count,
      output max_stall
`endif
   );
endinterface

// File: rtl/deadlock_watchdog_monitor.sv
// Per-kernel deadlock watchdog: declares a sticky deadlock after TIMEOUT consecutive stalled cycles.
// Optional statistics (event_count, max_stall) are built when DEADLOCK_MON_STATS_EN is defined.
module deadlock_watchdog_monitor #(
   parameter int N_AXIS  = 2,
   parameter int N_INST  = 2,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input logic                     kernel_monitor_clock,
   input logic                     kernel_monitor_reset,
   deadlock_watchdog_monitor_if.slave mon
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SUSPECT = 2'd1,
      BLOCKED = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              block_q, block_d;
   logic              pulse_q, pulse_d;
   logic [N_AXIS-1:0] axis_snap_q, axis_snap_d;
   logic [N_INST-1:0] inst_snap_q, inst_snap_d;
   logic              stall;
   logic              enter_blk;

   // A deadlock needs a real blocker and no instance still doing useful work.
   assign stall = (|mon.axis_block_sigs | |mon.inst_block_sigs)
                & (&(mon.inst_idle_sigs | mon.inst_block_sigs));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      block_d     = block_q;
      pulse_d     = 1'b0;
      axis_snap_d = axis_snap_q;
      inst_snap_d = inst_snap_q;
      enter_blk   = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!mon.clear && stall) begin
               if (TIMEOUT == 1) begin
                  state_d   = BLOCKED;
                  cnt_d     = TIMEOUT_C;
                  enter_blk = 1'b1;
               end else begin
                  state_d = SUSPECT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         SUSPECT: begin
            if (mon.clear || !stall) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LAST_C) begin
               state_d   = BLOCKED;
               cnt_d     = TIMEOUT_C;
               enter_blk = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         BLOCKED: begin
            if (mon.clear) begin
               state_d = IDLE;
               cnt_d   = '0;
               block_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            block_d = 1'b0;
         end
      endcase

      // Snapshot the blockers on the declaring edge so the diagnostic print shows the culprits.
      if (enter_blk) begin
         block_d     = 1'b1;
         pulse_d     = 1'b1;
         axis_snap_d = mon.axis_block_sigs;
         inst_snap_d = mon.inst_block_sigs;
      end
   end

   always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
      if (kernel_monitor_reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         block_q     <= 1'b0;
         pulse_q     <= 1'b0;
         axis_snap_q <= '0;
         inst_snap_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         block_q     <= block_d;
         pulse_q     <= pulse_d;
         axis_snap_q <= axis_snap_d;
         inst_snap_q <= inst_snap_d;
      end
   end

   assign mon.block         = block_q;
   assign mon.block_pulse   = pulse_q;
   assign mon.axis_snapshot = axis_snap_q;
   assign mon.inst_snapshot = inst_snap_q;
   assign mon.stall_count   = cnt_q;
   assign mon.state         = state_q;

`ifdef DEADLOCK_MON_STATS_EN
   logic [7:0]       event_count_q, event_count_d;
   logic [CNT_W-1:0] max_stall_q, max_stall_d;

   // Statistics survive clear; only reset zeroes them.
   always_comb begin
      event_count_d = event_count_q;
      max_stall_d   = max_stall_q;
      if (enter_blk && (event_count_q != 8'hFF)) begin
         event_count_d = event_count_q + 8'd1;
      end
      if (cnt_d > max_stall_q) begin
         max_stall_d = cnt_d;
      end
   end

   always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
      if (kernel_monitor_reset) begin
         event_count_q <= '0;
         max_stall_q   <= '0;
      end else begin
         event_count_q <= event_count_d;
         max_stall_q   <= max_stall_d;
      end
   end

   assign mon.event_count = event_count_q;
   assign mon.max_stall   = max_stall_q;
`endif

endmodule

// File: tb/tb_deadlock_watchdog_monitor.sv
// Self-checking bench: a TIMEOUT=16 and a TIMEOUT=1 watchdog share one stimulus stream
// and are compared every cycle against a run-length model of the stall rules.
module tb_deadlock_watchdog_monitor;

   localparam int N_AXIS = 2;
   localparam int N_INST = 2;
   localparam int CNT_W  = 16;
   localparam int TO_A   = 16;
   localparam int TO_B   = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] axisBlk  = '0;
   logic [1:0] instIdle = '0;
   logic [1:0] instBlk  = '0;
   logic       clr      = 1'b0;

   int nChecks = 0;
   int nFail   = 0;

   deadlock_watchdog_monitor_if #(.N_AXIS(N_AXIS), .N_INST(N_INST), .CNT_W(CNT_W)) ifA ();
   deadlock_watchdog_monitor_if #(.N_AXIS(N_AXIS), .N_INST(N_INST), .CNT_W(CNT_W)) ifB ();

   assign ifA.axis_block_sigs = axisBlk;
   assign ifA.inst_idle_sigs  = instIdle;
   assign ifA.inst_block_sigs = instBlk;
   assign ifA.clear           = clr;
   assign ifB.axis_block_sigs = axisBlk;
   assign ifB.inst_idle_sigs  = instIdle;
   assign ifB.inst_block_sigs = instBlk;
   assign ifB.clear           = clr;

   deadlock_watchdog_monitor #(.N_AXIS(N_AXIS), .N_INST(N_INST), .TIMEOUT(TO_A), .CNT_W(CNT_W)) dutA (
      .kernel_monitor_clock (clk),
      .kernel_monitor_reset (rst),
      .mon                  (ifA.slave)
   );

   deadlock_watchdog_monitor #(.N_AXIS(N_AXIS), .N_INST(N_INST), .TIMEOUT(TO_B), .CNT_W(CNT_W)) dutB (
      .kernel_monitor_clock (clk),
      .kernel_monitor_reset (rst),
      .mon                  (ifB.slave)
   );

   always #5 clk = ~clk;

   // Model: count the length of the current run of stalled cycles; a run of TIMEOUT declares.
   typedef struct {
      int         run;
      bit         blocked;
      bit         pulse;
      logic [1:0] axSnap;
      logic [1:0] inSnap;
      int         evt;
      int         maxStall;
   } modelT;

   modelT mA, mB;

   function automatic modelT resetModel();
      modelT m;
      m.run = 0; m.blocked = 0; m.pulse = 0;
      m.axSnap = '0; m.inSnap = '0; m.evt = 0; m.maxStall = 0;
      return m;
   endfunction

   function automatic bit stallNow();
      return ((axisBlk != 2'b00) || (instBlk != 2'b00)) && ((instIdle | instBlk) == 2'b11);
   endfunction

   function automatic modelT stepModel(modelT mIn, int timeout);
      modelT m = mIn;
      m.pulse = 0;
      if (clr) begin
         m.run = 0;
         m.blocked = 0;
      end else if (m.blocked) begin
         m.run = timeout;
      end else if (stallNow()) begin
         m.run = m.run + 1;
         if (m.run >= timeout) begin
            m.run = timeout;
            m.blocked = 1;
            m.pulse = 1;
            m.axSnap = axisBlk;
            m.inSnap = instBlk;
            if (m.evt < 255) m.evt = m.evt + 1;
         end
         if (m.run > m.maxStall) m.maxStall = m.run;
      end else begin
         m.run = 0;
      end
      return m;
   endfunction

   function automatic int expState(modelT m);
      if (m.blocked) return 2;
      if (m.run > 0) return 1;
      return 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mA = resetModel();
         mB = resetModel();
      end else begin
         mA = stepModel(mA, TO_A);
         mB = stepModel(mB, TO_B);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic compareDut(input string tag, input logic blk, input logic pls,
                             input logic [1:0] ax, input logic [1:0] in,
                             input logic [CNT_W-1:0] cnt, input logic [1:0] st, input modelT m);
      checkOutput({tag, ".block"},         32'(blk), 32'(m.blocked));
      checkOutput({tag, ".block_pulse"},   32'(pls), 32'(m.pulse));
      checkOutput({tag, ".axis_snapshot"}, 32'(ax),  32'(m.axSnap));
      checkOutput({tag, ".inst_snapshot"}, 32'(in),  32'(m.inSnap));
      checkOutput({tag, ".stall_count"},   32'(cnt), 32'(m.run));
      checkOutput({tag, ".state"},         32'(st),  32'(expState(m)));
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         compareDut("A", ifA.block, ifA.block_pulse, ifA.axis_snapshot, ifA.inst_snapshot,
                    ifA.stall_count, ifA.state, mA);
         compareDut("B", ifB.block, ifB.block_pulse, ifB.axis_snapshot, ifB.inst_snapshot,
                    ifB.stall_count, ifB.state, mB);
`ifdef DEADLOCK_MON_STATS_EN
         checkOutput("A.event_count", 32'(ifA.event_count), 32'(mA.evt));
         checkOutput("A.max_stall",   32'(ifA.max_stall),   32'(mA.maxStall));
         checkOutput("B.event_count", 32'(ifB.event_count), 32'(mB.evt));
         checkOutput("B.max_stall",   32'(ifB.max_stall),   32'(mB.maxStall));
`endif
      end
   end

   // Drive one input pattern for n rising edges, returning 2 time units after the last edge.
   task automatic applyStimulus(input logic [1:0] ax, input logic [1:0] idle,
                                input logic [1:0] ib, input logic c, input int n);
      axisBlk  = ax;
      instIdle = idle;
      instBlk  = ib;
      clr      = c;
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      checkOutput("reset.state", 32'(ifA.state), 32'd0);
      checkOutput("reset.block", 32'(ifA.block), 32'd0);

      applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 50);
      checkOutput("idle50.state", 32'(ifA.state), 32'd0);
      checkOutput("idle50.count", 32'(ifA.stall_count), 32'd0);

      applyStimulus(2'b01, 2'b11, 2'b00, 1'b0, 15);
      checkOutput("run15.block", 32'(ifA.block), 32'd0);
      checkOutput("run15.count", 32'(ifA.stall_count), 32'd15);
      checkOutput("to1.block", 32'(ifB.block), 32'd1);
      checkOutput("to1.axsnap", 32'(ifB.axis_snapshot), 32'h1);
      applyStimulus(2'b01, 2'b11, 2'b00, 1'b0, 1);
      checkOutput("run16.block", 32'(ifA.block), 32'd1);
      checkOutput("run16.pulse", 32'(ifA.block_pulse), 32'd1);
      checkOutput("run16.axsnap", 32'(ifA.axis_snapshot), 32'h1);
      checkOutput("run16.count", 32'(ifA.stall_count), 32'd16);
      applyStimulus(2'b01, 2'b11, 2'b00, 1'b0, 3);
      checkOutput("hold.pulse", 32'(ifA.block_pulse), 32'd0);
      checkOutput("hold.count", 32'(ifA.stall_count), 32'd16);

      applyStimulus(2'b01, 2'b11, 2'b00, 1'b1, 1);
      checkOutput("clr.block", 32'(ifA.block), 32'd0);
      checkOutput("clr.state", 32'(ifA.state), 32'd0);
      applyStimulus(2'b01, 2'b11, 2'b00, 1'b0, 1);
      checkOutput("reclr.state", 32'(ifA.state), 32'd1);
      checkOutput("reclr.count", 32'(ifA.stall_count), 32'd1);
      applyStimulus(2'b01, 2'b11, 2'b00, 1'b0, 15);
      checkOutput("redecl.block", 32'(ifA.block), 32'd1);
`ifdef DEADLOCK_MON_STATS_EN
      checkOutput("redecl.events", 32'(ifA.event_count), 32'd2);
`endif

      applyStimulus(2'b01, 2'b11, 2'b00, 1'b1, 1);
      applyStimulus(2'b01, 2'b11, 2'b00, 1'b0, 10);
      checkOutput("gap.count10", 32'(ifA.stall_count), 32'd10);
      applyStimulus(2'b00, 2'b11, 2'b00, 1'b0, 1);
      checkOutput("gap.count0", 32'(ifA.stall_count), 32'd0);
      checkOutput("gap.state", 32'(ifA.state), 32'd0);
      applyStimulus(2'b01, 2'b11, 2'b00, 1'b0, 15);
      checkOutput("gap.block15", 32'(ifA.block), 32'd0);
      applyStimulus(2'b01, 2'b11, 2'b00, 1'b0, 1);
      checkOutput("gap.block16", 32'(ifA.block), 32'd1);

      applyStimulus(2'b11, 2'b01, 2'b00, 1'b1, 1);
      applyStimulus(2'b11, 2'b01, 2'b00, 1'b0, 30);
      checkOutput("busy.blockA", 32'(ifA.block), 32'd0);
      checkOutput("busy.blockB", 32'(ifB.block), 32'd0);

      applyStimulus(2'b00, 2'b01, 2'b10, 1'b0, 16);
      checkOutput("inst.block", 32'(ifA.block), 32'd1);
      checkOutput("inst.insnap", 32'(ifA.inst_snapshot), 32'h2);
      checkOutput("inst.axsnap", 32'(ifA.axis_snapshot), 32'h0);

      applyStimulus(2'b00, 2'b01, 2'b10, 1'b1, 5);
      checkOutput("clrhold.stateA", 32'(ifA.state), 32'd0);
      checkOutput("clrhold.stateB", 32'(ifB.state), 32'd0);
      checkOutput("clrhold.snap", 32'(ifA.inst_snapshot), 32'h2);
      applyStimulus(2'b00, 2'b01, 2'b10, 1'b0, 1);
      checkOutput("to1b.block", 32'(ifB.block), 32'd1);
      checkOutput("to1b.stateA", 32'(ifA.state), 32'd1);

      #1 rst = 1'b1;
      #1;
      checkOutput("arst.blockB", 32'(ifB.block), 32'd0);
      checkOutput("arst.stateB", 32'(ifB.state), 32'd0);
      checkOutput("arst.snapB", 32'(ifB.inst_snapshot), 32'd0);
      checkOutput("arst.countA", 32'(ifA.stall_count), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      applyStimulus(2'b00, 2'b01, 2'b10, 1'b0, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/deadlock_watchdog_monitor.md
Name: deadlock_watchdog_monitor

Overview:
- Parametrised successor to the per-kernel deadlock monitor.
- Watches N_AXIS AXI-Stream blocking flags plus N_INST per-instance idle/block flags from the kernel under simulation.
- Declares a deadlock only after the stall condition has held for TIMEOUT consecutive cycles. The block flag is sticky until cleared, and the blocker set is snapshotted for the testbench's diagnostic print.
- Instantiated once per kernel inside the deadlock monitor top.

Parameters:
- N_AXIS, 2, number of AXI-Stream blocking inputs (>=1).
- N_INST, 2, number of monitored sub-instances (>=1).
- TIMEOUT, 16, consecutive stalled cycles required to declare a deadlock (1 to 2^CNT_W-1).
- CNT_W, 16, width of the stall counter.

Ports:
- kernel_monitor_clock  in  1  sole clock, rising edge.
- kernel_monitor_reset  in  1  asynchronous, active-high reset.
- axis_block_sigs  in  N_AXIS  1 = stream port blocked (inverted blk_n).
- inst_idle_sigs  in  N_INST  1 = instance idle.
- inst_block_sigs  in  N_INST  1 = instance internally blocked.
- clear  in  1  synchronous clear of a declared deadlock / detection state.
- block  out  1  sticky deadlock flag.
- block_pulse  out  1  one-cycle strobe on deadlock declaration.
- axis_snapshot  out  N_AXIS  axis_block_sigs captured at declaration.
- inst_snapshot  out  N_INST  inst_block_sigs captured at declaration.
- stall_count  out  CNT_W  current consecutive-stall count.
- state  out  2  FSM state: 0 IDLE, 1 SUSPECT, 2 BLOCKED.

Behaviour:
- Stall condition (combinational): stall = (|axis_block_sigs | |inst_block_sigs) & (&(inst_idle_sigs | inst_block_sigs)).
  - At least one blocker exists, and every instance is either idle or blocked.
- Reset (asynchronous, immediate): state=IDLE; stall_count=0; block=0; block_pulse=0; both snapshots=0; stats outputs=0.
- FSM transitions, evaluated at each rising edge:
  - IDLE:
    - clear -> IDLE.
    - stall and TIMEOUT==1 -> BLOCKED.
    - stall -> SUSPECT, stall_count=1.
    - otherwise stall_count stays 0.
  - SUSPECT:
    - clear or !stall -> IDLE, stall_count=0.
    - stall and stall_count==TIMEOUT-1 -> BLOCKED.
    - stall otherwise -> stall_count+1.
  - BLOCKED:
    - clear -> IDLE, stall_count=0.
    - otherwise hold. Inputs are ignored; stall_count holds at TIMEOUT (saturates, never wraps).
- Entry into BLOCKED, registered on that same edge:
  - block=1.
  - block_pulse=1 for exactly one cycle.
  - axis_snapshot and inst_snapshot load the current inputs.
- Latency: block rises on the edge that samples the TIMEOUT-th consecutive stalled cycle.
  - Example: stall first sampled at edge k -> block=1 after edge k+TIMEOUT-1.
- Any single unstalled cycle in SUSPECT restarts detection from 0.
- clear:
  - Has priority over stall in every state.
  - Deasserts block after the next edge.
  - Snapshots hold their last value until the next declaration.
  - clear held high keeps the FSM in IDLE.
- Stall persisting after clear: detection restarts on the following cycle, and re-declaration takes a full TIMEOUT.
- Reset mid-SUSPECT or mid-BLOCKED: immediate return to the reset values.
- All outputs are registered except none; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: DEADLOCK_MON_STATS_EN.
- Defined: adds ports event_count (out, 8) and max_stall (out, CNT_W).
  - event_count increments by 1 on each BLOCKED entry and saturates at 255.
  - max_stall tracks the largest stall_count reached in SUSPECT/BLOCKED.
  - Neither is affected by clear; only reset zeroes them.
- Not defined: those ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, all inputs 0 for 50 cycles -> state=0, block=0, stall_count=0 throughout.
- TIMEOUT=16, axis_block_sigs=2'b01, inst_idle_sigs=2'b11 held -> block rises after the 16th stalled edge; block_pulse high for 1 cycle; axis_snapshot=2'b01; stall_count=16 holds.
- Same stall but axis_block dropped for 1 cycle at count 10, then reasserted -> stall_count returns to 0 and re-counts; block rises 16 edges after reassertion.
- inst_idle_sigs=2'b01, inst_block_sigs=2'b00, axis blocked -> stall=0 (instance 1 busy); block never asserts.
- In BLOCKED, pulse clear 1 cycle with stall still true -> block=0 next cycle, state IDLE then SUSPECT; re-declared 16 cycles later, and event_count=2 with stats enabled.
- TIMEOUT=1 build, stall for 1 cycle -> block=1 after that edge. Assert kernel_monitor_reset asynchronously mid-BLOCKED -> block=0 immediately, without waiting for a clock edge.
